// File: rtl/alu_arbiter.sv
// Two-port valid/ready arbiter sharing one external ALU, one operation in flight at a time.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module alu_arbiter #(
    parameter int XLEN       = 32,
    parameter int SEL_SIZE   = 4,
    parameter int SHIFT_SIZE = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid_0,
    input  logic                  req_valid_1,
    output logic                  req_ready_0,
    output logic                  req_ready_1,
    input  logic [SEL_SIZE-1:0]   req_sel_0,
    input  logic [SEL_SIZE-1:0]   req_sel_1,
    input  logic [SHIFT_SIZE:0]   req_shift_0,
    input  logic [SHIFT_SIZE:0]   req_shift_1,
    input  logic [XLEN-1:0]       req_a_0,
    input  logic [XLEN-1:0]       req_a_1,
    input  logic [XLEN-1:0]       req_b_0,
    input  logic [XLEN-1:0]       req_b_1,
    output logic                  rsp_valid_0,
    output logic                  rsp_valid_1,
    input  logic                  rsp_ready_0,
    input  logic                  rsp_ready_1,
    output logic [XLEN-1:0]       rsp_data_0,
    output logic [XLEN-1:0]       rsp_data_1,
    output logic                  alu_enable,
    output logic [SEL_SIZE-1:0]   alu_sel,
    output logic [SHIFT_SIZE:0]   alu_shift_amt,
    output logic [XLEN-1:0]       alu_data_a,
    output logic [XLEN-1:0]       alu_data_b,
    input  logic [XLEN-1:0]       alu_data_out
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                state;
    logic [SEL_SIZE-1:0]   op_sel;
    logic [SHIFT_SIZE:0]   op_shift;
    logic [XLEN-1:0]       op_a;
    logic [XLEN-1:0]       op_b;
    logic                  op_owner;
    logic [XLEN-1:0]       result;
    logic                  grant_0;
    logic                  grant_1;
    logic                  accept;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // last_port remembers the previous winner; the other port wins the next tie
    logic last_port;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_port <= 1'b1;
        end else if (accept) begin
            last_port <= req_ready_1;
        end
    end

    assign grant_0 = req_valid_0 & (~req_valid_1 | last_port);
    assign grant_1 = req_valid_1 & (~req_valid_0 | ~last_port);
`else
    assign grant_0 = req_valid_0;
    assign grant_1 = req_valid_1 & ~req_valid_0;
`endif

    assign req_ready_0 = (state == IDLE) & grant_0;
    assign req_ready_1 = (state == IDLE) & grant_1;
    assign accept      = req_ready_0 | req_ready_1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            op_sel      <= '0;
            op_shift    <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_owner    <= 1'b0;
            result      <= '0;
            alu_enable  <= 1'b0;
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_sel     <= req_ready_1 ? req_sel_1   : req_sel_0;
                        op_shift   <= req_ready_1 ? req_shift_1 : req_shift_0;
                        op_a       <= req_ready_1 ? req_a_1     : req_a_0;
                        op_b       <= req_ready_1 ? req_b_1     : req_b_0;
                        op_owner   <= req_ready_1;
                        alu_enable <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    result      <= alu_data_out;
                    alu_enable  <= 1'b0;
                    rsp_valid_0 <= ~op_owner;
                    rsp_valid_1 <= op_owner;
                    state       <= RESP;
                end
                RESP: begin
                    if (op_owner ? rsp_ready_1 : rsp_ready_0) begin
                        rsp_valid_0 <= 1'b0;
                        rsp_valid_1 <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The ALU and response buses are forced to zero whenever they carry nothing meaningful
    assign alu_sel       = alu_enable ? op_sel   : '0;
    assign alu_shift_amt = alu_enable ? op_shift : '0;
    assign alu_data_a    = alu_enable ? op_a     : '0;
    assign alu_data_b    = alu_enable ? op_b     : '0;
    assign rsp_data_0    = rsp_valid_0 ? result : '0;
    assign rsp_data_1    = rsp_valid_1 ? result : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run against a
// transaction-level model. Expectations follow ALU_ARB_ROUND_ROBIN_EN when it is defined.
module tb_alu_arbiter;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    localparam bit RoundRobin = 1'b1;
`else
    localparam bit RoundRobin = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [3:0]  req_sel_0, req_sel_1;
    logic [5:0]  req_shift_0, req_shift_1;
    logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
    logic        rsp_valid_0, rsp_valid_1;
    logic        rsp_ready_0, rsp_ready_1;
    logic [31:0] rsp_data_0, rsp_data_1;
    logic        alu_enable;
    logic [3:0]  alu_sel;
    logic [5:0]  alu_shift_amt;
    logic [31:0] alu_data_a, alu_data_b, alu_data_out;

    int checks = 0;
    int errors = 0;

    alu_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_sel_0(req_sel_0), .req_sel_1(req_sel_1),
        .req_shift_0(req_shift_0), .req_shift_1(req_shift_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
        .rsp_data_0(rsp_data_0), .rsp_data_1(rsp_data_1),
        .alu_enable(alu_enable), .alu_sel(alu_sel), .alu_shift_amt(alu_shift_amt),
        .alu_data_a(alu_data_a), .alu_data_b(alu_data_b), .alu_data_out(alu_data_out)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: ADD=0, SUB=1, AND=2, OR=3, SLTU=4, SRL=5, XOR=6, SLL=7, others add
    function automatic logic [31:0] alu_ref(input logic [3:0] sel, input logic [5:0] sh,
                                            input logic [31:0] a, input logic [31:0] b);
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return {31'd0, a < b};
            4'd5:    return a >> sh;
            4'd6:    return a ^ b;
            4'd7:    return a << sh;
            default: return a + b;
        endcase
    endfunction

    always_comb alu_data_out = alu_ref(alu_sel, alu_shift_amt, alu_data_a, alu_data_b);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid_0 = 0; req_valid_1 = 0;
        req_sel_0 = 0; req_sel_1 = 0; req_shift_0 = 0; req_shift_1 = 0;
        req_a_0 = 0; req_a_1 = 0; req_b_0 = 0; req_b_1 = 0;
        rsp_ready_0 = 0; rsp_ready_1 = 0;
    endtask

    task automatic do_reset();
        tick();
        clear_inputs();
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 0;
        #3;
        checks++;
        if ({req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, alu_enable} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b want 00000",
                     {req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, alu_enable});
        end
        checks++;
        if ({alu_sel, alu_shift_amt, alu_data_a, alu_data_b, rsp_data_0, rsp_data_1} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_buses: sel=%0h sh=%0h a=%0h b=%0h d0=%0h d1=%0h want all 0",
                     alu_sel, alu_shift_amt, alu_data_a, alu_data_b, rsp_data_0, rsp_data_1);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1;
        req_valid_1 = 1;
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL reset_idle_grant: got r0=%b r1=%b want r0=0 r1=1", req_ready_0, req_ready_1);
        end
        #1;
        req_valid_1 = 0;
    endtask

    task automatic test_single_op();
        tick();
        req_valid_0 = 1; req_sel_0 = 4'd0; req_a_0 = 32'd5; req_b_0 = 32'd7; req_shift_0 = 0;
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL single_ready: got r0=%b r1=%b want r0=1 r1=0", req_ready_0, req_ready_1);
        end
        tick();
        req_valid_0 = 0;
        #1;
        checks++;
        if (alu_enable !== 1'b1 || alu_data_a !== 32'd5 || alu_data_b !== 32'd7 || alu_sel !== 4'd0) begin
            errors++;
            $display("[TB] FAIL single_exec: got en=%b a=%0d b=%0d sel=%0d want en=1 a=5 b=7 sel=0",
                     alu_enable, alu_data_a, alu_data_b, alu_sel);
        end
        tick();
        #1;
        checks++;
        if (rsp_valid_0 !== 1'b1 || rsp_data_0 !== 32'd12 || rsp_valid_1 !== 1'b0 || rsp_data_1 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL single_rsp: got v0=%b d0=%0d v1=%b d1=%0d want v0=1 d0=12 v1=0 d1=0",
                     rsp_valid_0, rsp_data_0, rsp_valid_1, rsp_data_1);
        end
        rsp_ready_0 = 1;
        tick();
        rsp_ready_0 = 0;
        checks++;
        if (rsp_valid_0 !== 1'b0 || rsp_data_0 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL single_release: got v0=%b d0=%0d want v0=0 d0=0", rsp_valid_0, rsp_data_0);
        end
    endtask

    task automatic test_back_pressure();
        tick();
        req_valid_1 = 1; req_sel_1 = 4'd7; req_a_1 = 32'd1; req_b_1 = 32'd0; req_shift_1 = 6'd4;
        rsp_ready_1 = 0;
        #1;
        checks++;
        if (req_ready_1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_accept: got r1=%b want 1", req_ready_1);
        end
        tick();
        req_valid_1 = 0;
        req_valid_0 = 1; req_sel_0 = 4'd0; req_a_0 = 32'd10; req_b_0 = 32'd20; req_shift_0 = 0;
        #1;
        checks++;
        if (req_ready_0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_exec_ready: got r0=%b want 0", req_ready_0);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rsp_valid_1 !== 1'b1 || rsp_data_1 !== 32'd16 || rsp_valid_0 !== 1'b0 ||
                req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d]: got v1=%b d1=%0d v0=%b r0=%b r1=%b want v1=1 d1=16 v0=0 r0=0 r1=0",
                         i, rsp_valid_1, rsp_data_1, rsp_valid_0, req_ready_0, req_ready_1);
            end
            tick();
        end
        rsp_ready_1 = 1;
        tick();
        rsp_ready_1 = 0;
        #1;
        checks++;
        if (rsp_valid_1 !== 1'b0 || req_ready_0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_idle: got v1=%b r0=%b want v1=0 r0=1", rsp_valid_1, req_ready_0);
        end
        tick();
        req_valid_0 = 0;
        tick();
        #1;
        checks++;
        if (rsp_valid_0 !== 1'b1 || rsp_data_0 !== 32'd30) begin
            errors++;
            $display("[TB] FAIL bp_followup: got v0=%b d0=%0d want v0=1 d0=30", rsp_valid_0, rsp_data_0);
        end
        rsp_ready_0 = 1;
        tick();
        rsp_ready_0 = 0;
    endtask

    task automatic test_stray_rsp_ready();
        rsp_ready_0 = 1;
        rsp_ready_1 = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (rsp_valid_0 !== 1'b0 || rsp_valid_1 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stray_idle[%0d]: got v0=%b v1=%b want 0 0", i, rsp_valid_0, rsp_valid_1);
            end
            tick();
        end
        req_valid_1 = 1; req_sel_1 = 4'd6; req_a_1 = 32'hF0; req_b_1 = 32'hFF; req_shift_1 = 0;
        #1;
        checks++;
        if (req_ready_1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stray_accept: got r1=%b want 1", req_ready_1);
        end
        tick();
        req_valid_1 = 0;
        tick();
        #1;
        checks++;
        if (rsp_valid_1 !== 1'b1 || rsp_data_1 !== 32'h0F || rsp_valid_0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stray_rsp: got v1=%b d1=%0h v0=%b want v1=1 d1=f v0=0",
                     rsp_valid_1, rsp_data_1, rsp_valid_0);
        end
        tick();
        #1;
        checks++;
        if (rsp_valid_1 !== 1'b0 || rsp_valid_0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stray_done: got v0=%b v1=%b want 0 0", rsp_valid_0, rsp_valid_1);
        end
        rsp_ready_0 = 0;
        rsp_ready_1 = 0;
    endtask

    task automatic test_reset_mid_exec();
        tick();
        req_valid_0 = 1; req_sel_0 = 4'd0; req_a_0 = 32'd9; req_b_0 = 32'd9;
        tick();
        req_valid_0 = 0;
        #1;
        checks++;
        if (alu_enable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_in_exec: got en=%b want 1", alu_enable);
        end
        #1;
        reset_n = 0;
        #1;
        checks++;
        if ({alu_enable, rsp_valid_0, rsp_valid_1, req_ready_0, req_ready_1} !== 5'b0 ||
            alu_data_a !== 32'd0 || alu_data_b !== 32'd0 || rsp_data_0 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midrst_async: got en=%b v0=%b v1=%b a=%0d b=%0d d0=%0d want all 0",
                     alu_enable, rsp_valid_0, rsp_valid_1, alu_data_a, alu_data_b, rsp_data_0);
        end
        tick();
        tick();
        reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (rsp_valid_0 !== 1'b0 || rsp_valid_1 !== 1'b0 || alu_enable !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midrst_dropped[%0d]: got v0=%b v1=%b en=%b want 0 0 0",
                         i, rsp_valid_0, rsp_valid_1, alu_enable);
            end
            tick();
        end
        req_valid_0 = 1; req_sel_0 = 4'd0; req_a_0 = 32'd3; req_b_0 = 32'd4;
        tick();
        req_valid_0 = 0;
        tick();
        #1;
        checks++;
        if (rsp_valid_0 !== 1'b1 || rsp_data_0 !== 32'd7) begin
            errors++;
            $display("[TB] FAIL midrst_next: got v0=%b d0=%0d want v0=1 d0=7", rsp_valid_0, rsp_data_0);
        end
        rsp_ready_0 = 1;
        tick();
        rsp_ready_0 = 0;
    endtask

    task automatic test_contention();
        int ngr;
        int last_cyc;
        int want;
        do_reset();
        req_valid_0 = 1; req_sel_0 = 4'd0; req_a_0 = 32'd1; req_b_0 = 32'd1;
        req_valid_1 = 1; req_sel_1 = 4'd0; req_a_1 = 32'd2; req_b_1 = 32'd2;
        rsp_ready_0 = 1; rsp_ready_1 = 1;
        ngr = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 40 && ngr < 4; cyc++) begin
            #1;
            if (req_ready_0 || req_ready_1) begin
                want = RoundRobin ? (ngr % 2) : 0;
                checks++;
                if ({req_ready_1, req_ready_0} !== (want == 1 ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("[TB] FAIL contention_grant[%0d]: got r0=%b r1=%b want port %0d",
                             ngr, req_ready_0, req_ready_1, want);
                end
                if (ngr > 0) begin
                    checks++;
                    if (cyc - last_cyc != 3) begin
                        errors++;
                        $display("[TB] FAIL contention_spacing[%0d]: got %0d cycles want 3", ngr, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                ngr++;
            end
            if (rsp_valid_0 || rsp_valid_1) begin
                checks++;
                if ((rsp_valid_0 && rsp_data_0 !== 32'd2) || (rsp_valid_1 && rsp_data_1 !== 32'd4) ||
                    (rsp_valid_0 && rsp_valid_1)) begin
                    errors++;
                    $display("[TB] FAIL contention_rsp: got v0=%b d0=%0d v1=%b d1=%0d want d0=2 d1=4 one valid",
                             rsp_valid_0, rsp_data_0, rsp_valid_1, rsp_data_1);
                end
            end
            tick();
        end
        checks++;
        if (ngr != 4) begin
            errors++;
            $display("[TB] FAIL contention_timeout: got %0d grants want 4", ngr);
        end
        req_valid_0 = 0;
        req_valid_1 = 0;
        repeat (4) tick();
        rsp_ready_0 = 0;
        rsp_ready_1 = 0;
    endtask

    // Transaction model: one op in flight, EXEC the cycle after accept, response from the next
    task automatic test_random();
        logic        busy, owner, last_win, want_win, hs0, hs1;
        int          age, accepts;
        logic [3:0]  exp_sel;
        logic [5:0]  exp_sh;
        logic [31:0] exp_a, exp_b, exp_data;
        do_reset();
        busy = 0; owner = 0; last_win = 1; hs0 = 0; hs1 = 0; age = 0; accepts = 0;
        exp_sel = 0; exp_sh = 0; exp_a = 0; exp_b = 0; exp_data = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (hs0) req_valid_0 = 0;
            if (hs1) req_valid_1 = 0;
            if (!req_valid_0 && $urandom_range(0, 1) == 1) begin
                req_valid_0 = 1;
                req_sel_0 = 4'($urandom_range(0, 15));
                req_shift_0 = 6'($urandom_range(0, 63));
                req_a_0 = $urandom;
                req_b_0 = $urandom;
            end
            if (!req_valid_1 && $urandom_range(0, 1) == 1) begin
                req_valid_1 = 1;
                req_sel_1 = 4'($urandom_range(0, 15));
                req_shift_1 = 6'($urandom_range(0, 63));
                req_a_1 = $urandom;
                req_b_1 = $urandom;
            end
            rsp_ready_0 = ($urandom_range(0, 3) != 0);
            rsp_ready_1 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hs0 = req_valid_0 & req_ready_0;
            hs1 = req_valid_1 & req_ready_1;
            if (busy) begin
                age++;
                checks++;
                if (req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL rand_busy_ready c%0d: got r0=%b r1=%b want 0 0", cyc, req_ready_0, req_ready_1);
                end
                if (age == 1) begin
                    checks++;
                    if (alu_enable !== 1'b1 || alu_sel !== exp_sel || alu_shift_amt !== exp_sh ||
                        alu_data_a !== exp_a || alu_data_b !== exp_b || rsp_valid_0 !== 1'b0 || rsp_valid_1 !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL rand_exec c%0d: got en=%b sel=%0h sh=%0h a=%0h b=%0h want en=1 sel=%0h sh=%0h a=%0h b=%0h",
                                 cyc, alu_enable, alu_sel, alu_shift_amt, alu_data_a, alu_data_b,
                                 exp_sel, exp_sh, exp_a, exp_b);
                    end
                end else begin
                    checks++;
                    if (alu_enable !== 1'b0 ||
                        {rsp_valid_1, rsp_valid_0} !== (owner ? 2'b10 : 2'b01) ||
                        (owner ? rsp_data_1 : rsp_data_0) !== exp_data ||
                        (owner ? rsp_data_0 : rsp_data_1) !== 32'd0) begin
                        errors++;
                        $display("[TB] FAIL rand_rsp c%0d: got en=%b v0=%b v1=%b d0=%0h d1=%0h want port %0d data %0h",
                                 cyc, alu_enable, rsp_valid_0, rsp_valid_1, rsp_data_0, rsp_data_1, owner, exp_data);
                    end
                    if (owner ? rsp_ready_1 : rsp_ready_0) busy = 0;
                end
            end else begin
                checks++;
                if (alu_enable !== 1'b0 || rsp_valid_0 !== 1'b0 || rsp_valid_1 !== 1'b0 ||
                    rsp_data_0 !== 32'd0 || rsp_data_1 !== 32'd0) begin
                    errors++;
                    $display("[TB] FAIL rand_idle c%0d: got en=%b v0=%b v1=%b d0=%0h d1=%0h want all 0",
                             cyc, alu_enable, rsp_valid_0, rsp_valid_1, rsp_data_0, rsp_data_1);
                end
                want_win = (req_valid_0 && req_valid_1) ? (RoundRobin ? ~last_win : 1'b0) : req_valid_1;
                checks++;
                if ({req_ready_1, req_ready_0} !== ((req_valid_0 || req_valid_1) ?
                                                    (want_win ? 2'b10 : 2'b01) : 2'b00)) begin
                    errors++;
                    $display("[TB] FAIL rand_grant c%0d: got r0=%b r1=%b with v0=%b v1=%b want port %0d",
                             cyc, req_ready_0, req_ready_1, req_valid_0, req_valid_1, want_win);
                end
                if (hs0 || hs1) begin
                    owner    = hs1;
                    exp_sel  = hs1 ? req_sel_1 : req_sel_0;
                    exp_sh   = hs1 ? req_shift_1 : req_shift_0;
                    exp_a    = hs1 ? req_a_1 : req_a_0;
                    exp_b    = hs1 ? req_b_1 : req_b_0;
                    exp_data = alu_ref(exp_sel, exp_sh, exp_a, exp_b);
                    last_win = owner;
                    busy     = 1;
                    age      = 0;
                    accepts++;
                end
            end
            tick();
        end
        checks++;
        if (accepts < 20) begin
            errors++;
            $display("[TB] FAIL rand_progress: got %0d accepts want at least 20", accepts);
        end
        req_valid_0 = 0;
        req_valid_1 = 0;
        rsp_ready_0 = 1;
        rsp_ready_1 = 1;
        repeat (4) tick();
        rsp_ready_0 = 0;
        rsp_ready_1 = 0;
    endtask

    initial begin
        clk = 0;
        test_reset();
        test_single_op();
        test_back_pressure();
        test_stray_rsp_ready();
        test_reset_mid_exec();
        test_contention();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single execute-stage ALU between two requesters: port 0 (integer execute) and port 1 (load/store address generation). Each port issues with a valid/ready handshake and receives its result on a per-port valid/ready response channel. One operation is in flight at a time. Operands are registered before they reach the ALU, which breaks the path from the requesters into the ALU.

## Interface
- XLEN, 32, datapath width
- SEL_SIZE, 4, ALU operation select width
- SHIFT_SIZE, 5, shift amount port is SHIFT_SIZE+1 bits wide
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid_0 / req_valid_1  in  1  request valid per port
- req_ready_0 / req_ready_1  out  1  request accepted this cycle
- req_sel_0 / req_sel_1  in  SEL_SIZE  ALU operation
- req_shift_0 / req_shift_1  in  SHIFT_SIZE+1  shift amount
- req_a_0 / req_a_1, req_b_0 / req_b_1  in  XLEN  operands A and B
- rsp_valid_0 / rsp_valid_1  out  1  result valid per port
- rsp_ready_0 / rsp_ready_1  in  1  requester takes the result
- rsp_data_0 / rsp_data_1  out  XLEN  result
- alu_enable  out  1  ALU enable
- alu_sel  out  SEL_SIZE  to the ALU select input
- alu_shift_amt  out  SHIFT_SIZE+1  to the ALU shift amount input
- alu_data_a / alu_data_b  out  XLEN  to the ALU operand inputs
- alu_data_out  in  XLEN  ALU result (combinational)

## Operation
FSM states are IDLE, EXEC and RESP. The reset state is IDLE.
- **IDLE**
  - Arbitrate among the asserted req_valid_x.
  - req_ready_x = 1 only for the winner. This is combinational from both req_valid inputs and the state.
  - On a handshake: latch sel, shift, a, b and owner into the operand registers, update the priority pointer, then go to EXEC.
  - No valid request: stay in IDLE.
- **EXEC** (exactly one cycle)
  - alu_enable = 1, and the alu_* outputs are driven from the operand registers.
  - alu_data_out is captured into the result register, then go to RESP.
- **RESP**
  - rsp_valid_owner = 1 and rsp_data_owner = result register.
  - Hold until rsp_ready_owner = 1, then go to IDLE.
  - The non-owner's rsp_valid stays 0.
- Outside EXEC: alu_enable = 0 and alu_sel, alu_shift_amt, alu_data_a, alu_data_b = 0.
- rsp_data_x reads 0 whenever rsp_valid_x = 0.
- Operands pass unmodified to the ALU. The arbiter does no width extension; sign extension of the LOAD/STORE offset is done by the ALU.
- Requests arriving in EXEC or RESP see req_ready = 0. A requester must hold valid and its fields stable until ready.
- Priority pointer: 1 bit, holds the port accepted last.
  - Reset value 1, so port 0 wins the first tie.
  - When both ports are valid, the port not pointed to wins.
  - When one port is valid, it wins regardless of the pointer.

## Timing
- Accept on the edge closing cycle T; EXEC in T+1; rsp_valid asserted from T+2.
- Latency from handshake to rsp_valid is 2 cycles.
- Peak throughput is 1 op per 3 cycles (rsp_ready tied high).
- rsp_ready high in the first RESP cycle: IDLE in T+3, so the next accept can occur in T+3.
- Reset values:
  - state = IDLE, pointer = 1, operand and result registers = 0.
  - All outputs 0: req_ready, rsp_valid, rsp_data and alu_*.
- Reset asserted mid-operation (EXEC or RESP):
  - Outputs go to reset values immediately (asynchronous).
  - The in-flight operation is dropped; no response is ever issued for it.
- rsp_ready while rsp_valid = 0 is ignored.
- req_valid deasserted without ready is legal: nothing is latched.

## Configuration
- ALU_ARB_ROUND_ROBIN_EN defined: the round-robin pointer is used as described in Operation.
- ALU_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority, port 0 always wins ties.
  - The pointer register is not instantiated.
  - All other behaviour is unchanged.

## Test plan
- **Single op, port 0:** reset, then port 0 issues ADD (sel 0), a=5, b=7 -> req_ready_0=1 in the issue cycle, alu_enable=1 one cycle later, rsp_valid_0=1 and rsp_data_0=12 two cycles after the handshake.
- **Back-pressure, port 1:** port 1 issues SLL (sel 7), a=1, shift=4; rsp_ready_1 held low 5 cycles -> rsp_data_1=16 stays stable, rsp_valid_1=1 throughout, req_ready_0=req_ready_1=0 throughout, IDLE the cycle after rsp_ready_1=1.
- **Contention, round-robin (macro defined):** both ports valid continuously, rsp_ready high -> grant order 0,1,0,1; each port gets a response every 6 cycles.
- **Contention, fixed priority (macro undefined):** same stimulus as the round-robin case -> port 0 granted every time, req_ready_1 never asserted.
- **Reset mid-EXEC:** assert reset_n=0 during EXEC -> alu_enable=0 and all outputs 0 within the same cycle; after release no rsp_valid appears; the next request (ADD a=3, b=4) returns 7.
- **Stray rsp_ready:** rsp_ready_0=1 while IDLE, then port 1 request XOR (sel 6), a=0xF0, b=0xFF -> rsp_valid_0 never asserts, rsp_valid_1=1 with rsp_data_1=0x0F.
